// File: rtl/muldiv_pkg.sv
// Shared definitions for the MIPS multiply/divide sequencer: operation
// encodings, FSM state type and the fixed iteration count.
package muldiv_pkg;

    localparam int ITERATIONS = 32;

    localparam logic [1:0] OP_MULT  = 2'b00;
    localparam logic [1:0] OP_MULTU = 2'b01;
    localparam logic [1:0] OP_DIV   = 2'b10;
    localparam logic [1:0] OP_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        PREP = 2'b01,
        ITER = 2'b10,
        FIX  = 2'b11
    } state_t;

endpackage

// File: rtl/muldiv_step.sv
// One iteration of the multiply/divide loop, purely combinational.
// Multiply: conditional add of the multiplicand into the upper half with a
// carry bit, then shift the whole accumulator right by one.
// Divide: shift {remainder, quotient} left pulling in the next dividend bit,
// trial-subtract the divisor and either keep the difference or restore.
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic               is_div,
    input  logic [2*WIDTH-1:0] acc,
    input  logic [WIDTH-1:0]   operand,
    input  logic               mul_bit,
    input  logic               div_bit,
    output logic [2*WIDTH-1:0] acc_next
);

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   shifted;
    logic [WIDTH-1:0] diff;
    logic             negative;

    // The trial difference only needs the low WIDTH bits: whenever it is kept
    // it is smaller than the divisor, so the wrapped subtraction is exact.
    // The borrow is taken from a full-width compare of the shifted remainder.
    always_comb begin
        acc_next = acc;
        sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (mul_bit ? {1'b0, operand} : '0);
        shifted  = {acc[2*WIDTH-1:WIDTH], div_bit};
        diff     = shifted[WIDTH-1:0] - operand;
        negative = (shifted < {1'b0, operand});
        if (is_div) begin
            if (negative) begin
                acc_next = {shifted[WIDTH-1:0], acc[WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {diff, acc[WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_next = {sum, acc[WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/muldiv_ctrl.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO registers.
// Operands are latched in IDLE, reduced to magnitudes in PREP, run through
// 32 shift-add or restoring-subtract iterations in ITER, and sign-corrected
// and written to HI/LO in FIX.
module muldiv_ctrl
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] Data1,
    input  logic [WIDTH-1:0] Data2,
    input  logic             mthi,
    input  logic             mtlo,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam logic [5:0] LAST_COUNT = 6'(ITERATIONS - 1);

    state_t             state;
    state_t             state_next;
    logic [5:0]         count;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] acc_step;
    logic [WIDTH-1:0]   a_reg;
    logic [WIDTH-1:0]   b_reg;
    logic [1:0]         op_reg;
    logic               res_sign;
    logic               rem_sign;

    logic               is_div;
    logic               is_signed;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [2*WIDTH-1:0] prod_fixed;
    logic [WIDTH-1:0]   quot_fixed;
    logic [WIDTH-1:0]   rem_fixed;

    assign busy = (state != IDLE);

    // During ITER a_reg holds the bits still to be consumed: the multiplier
    // (consumed from the LSB) or the dividend (consumed from the MSB);
    // b_reg holds the multiplicand or divisor.
    muldiv_step #(.WIDTH(WIDTH)) u_step (
        .is_div   (is_div),
        .acc      (acc),
        .operand  (b_reg),
        .mul_bit  (a_reg[0]),
        .div_bit  (a_reg[WIDTH-1]),
        .acc_next (acc_step)
    );

    // Operation decode, operand magnitudes and final sign correction.
    always_comb begin
        is_div     = (op_reg == OP_DIV) || (op_reg == OP_DIVU);
        is_signed  = (op_reg == OP_MULT) || (op_reg == OP_DIV);
        a_neg      = is_signed & a_reg[WIDTH-1];
        b_neg      = is_signed & b_reg[WIDTH-1];
        a_mag      = a_neg ? ('0 - a_reg) : a_reg;
        b_mag      = b_neg ? ('0 - b_reg) : b_reg;
        prod_fixed = res_sign ? ('0 - acc) : acc;
        quot_fixed = res_sign ? ('0 - acc[WIDTH-1:0]) : acc[WIDTH-1:0];
        rem_fixed  = rem_sign ? ('0 - acc[2*WIDTH-1:WIDTH]) : acc[2*WIDTH-1:WIDTH];
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: a start is only honoured from IDLE.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = PREP;
            PREP:    state_next = ITER;
            ITER:    if (count == LAST_COUNT) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath, iteration counter, HI/LO and the done pulse.
    always_ff @(posedge clk) begin
        if (reset) begin
            count    <= '0;
            acc      <= '0;
            a_reg    <= '0;
            b_reg    <= '0;
            op_reg   <= '0;
            res_sign <= 1'b0;
            rem_sign <= 1'b0;
            hi       <= '0;
            lo       <= '0;
            done     <= 1'b0;
        end else begin
            done <= (state == FIX);
            case (state)
                IDLE: begin
                    if (start) begin
                        a_reg  <= Data1;
                        b_reg  <= Data2;
                        op_reg <= op;
                    end
                    if (mthi) hi <= Data1;
                    if (mtlo) lo <= Data1;
                end
                PREP: begin
                    if (is_div) begin
                        a_reg <= a_mag;
                        b_reg <= b_mag;
                    end else begin
                        a_reg <= b_mag;
                        b_reg <= a_mag;
                    end
                    res_sign <= a_neg ^ b_neg;
                    rem_sign <= a_neg;
                    count    <= '0;
                    acc      <= '0;
                end
                ITER: begin
                    acc   <= acc_step;
                    count <= count + 6'd1;
                    if (is_div) begin
                        a_reg <= {a_reg[WIDTH-2:0], 1'b0};
                    end else begin
                        a_reg <= {1'b0, a_reg[WIDTH-1:1]};
                    end
                end
                FIX: begin
                    if (is_div) begin
                        hi <= rem_fixed;
                        lo <= quot_fixed;
                    end else begin
                        hi <= prod_fixed[2*WIDTH-1:WIDTH];
                        lo <= prod_fixed[WIDTH-1:0];
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed corner cases, hazard cases
// (start/mthi while busy, back-to-back, mid-operation reset) and randomized
// operations checked against an arithmetic reference model.
module tb_muldiv_ctrl;

   localparam logic [1:0] OP_MULT  = 2'b00;
   localparam logic [1:0] OP_MULTU = 2'b01;
   localparam logic [1:0] OP_DIV   = 2'b10;
   localparam logic [1:0] OP_DIVU  = 2'b11;

   logic        clk;
   logic        reset;
   logic        start;
   logic [1:0]  op;
   logic [31:0] Data1;
   logic [31:0] Data2;
   logic        mthi;
   logic        mtlo;
   logic        busy;
   logic        done;
   logic [31:0] hi;
   logic [31:0] lo;

   int total;
   int bad;

   muldiv_ctrl #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .op    (op),
      .Data1 (Data1),
      .Data2 (Data2),
      .mthi  (mthi),
      .mtlo  (mtlo),
      .busy  (busy),
      .done  (done),
      .hi    (hi),
      .lo    (lo)
   );

   // Free-running clock.
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference result {HI, LO} computed from the architectural definition.
   function automatic logic [63:0] refModel(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
      longint      sp;
      logic [63:0] up;
      logic        sgn;
      logic        an;
      logic        bn;
      logic [31:0] am;
      logic [31:0] bm;
      logic [31:0] q;
      logic [31:0] r;
      if (o == OP_MULT) begin
         sp = longint'($signed(a)) * longint'($signed(b));
         return sp;
      end
      if (o == OP_MULTU) begin
         up = {32'd0, a} * {32'd0, b};
         return up;
      end
      sgn = (o == OP_DIV);
      an  = sgn && a[31];
      bn  = sgn && b[31];
      am  = an ? (32'd0 - a) : a;
      bm  = bn ? (32'd0 - b) : b;
      if (bm == 32'd0) begin
         q = 32'hFFFF_FFFF;
         r = am;
      end else begin
         q = am / bm;
         r = am % bm;
      end
      if (an ^ bn) q = 32'd0 - q;
      if (an) r = 32'd0 - r;
      return {r, q};
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
      total++;
      assert (observed === expected)
      else begin
         bad++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   // Drive one request at a falling edge, hold it across the next rising
   // edge, then release the strobes.
   task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic st, input logic mh, input logic ml);
      op    = o;
      Data1 = a;
      Data2 = b;
      start = st;
      mthi  = mh;
      mtlo  = ml;
      @(posedge clk);
      #1;
      start = 1'b0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
   endtask

   // Wait (bounded) for done; returns rising edges since the accepting edge
   // and how many sampled cycles had busy high. Returns in the done cycle.
   task automatic waitDone(output int edges, output int busyCycles);
      edges      = 999;
      busyCycles = 0;
      for (int n = 1; n <= 60; n++) begin
         @(negedge clk);
         if (busy) busyCycles++;
         if (done) begin
            edges = n - 1;
            break;
         end
      end
   endtask

   task automatic doOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] expected, input string tag);
      int edges;
      int busyCycles;
      applyStimulus(o, a, b, 1'b1, 1'b0, 1'b0);
      waitDone(edges, busyCycles);
      checkOutput({tag, "_latency"}, 64'(edges), 64'd34);
      checkOutput({tag, "_busy"}, 64'(busyCycles), 64'd34);
      checkOutput({tag, "_hi"}, {32'd0, hi}, {32'd0, expected[63:32]});
      checkOutput({tag, "_lo"}, {32'd0, lo}, {32'd0, expected[31:0]});
      @(negedge clk);
      checkOutput({tag, "_done_pulse"}, {63'd0, done}, 64'd0);
   endtask

   initial begin
      int          edges;
      int          busyCycles;
      int          doneSeen;
      logic [1:0]  rop;
      logic [31:0] ra;
      logic [31:0] rb;

      total = 0;
      bad   = 0;
      reset = 1'b1;
      start = 1'b0;
      op    = 2'b00;
      Data1 = '0;
      Data2 = '0;
      mthi  = 1'b0;
      mtlo  = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("reset_busy", {63'd0, busy}, 64'd0);
      checkOutput("reset_done", {63'd0, done}, 64'd0);
      checkOutput("reset_hilo", {hi, lo}, 64'd0);

      // Directed corner cases.
      doOp(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "multu_max");
      doOp(OP_MULT,  32'hFFFF_FFFD, 32'd5,         64'hFFFF_FFFF_FFFF_FFF1, "mult_neg3x5");
      doOp(OP_MULT,  32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000, "mult_minxmin");
      doOp(OP_DIV,   32'hFFFF_FFF9, 32'd2,         64'hFFFF_FFFF_FFFF_FFFD, "div_neg7by2");
      doOp(OP_DIVU,  32'd100,       32'd7,         64'h0000_0002_0000_000E, "divu_100by7");
      doOp(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000, "div_overflow");
      doOp(OP_DIVU,  32'd7,         32'd0,         64'h0000_0007_FFFF_FFFF, "divu_by0");
      doOp(OP_DIV,   32'hFFFF_FFF9, 32'd0,         64'hFFFF_FFF9_0000_0001, "div_neg_by0");

      // start and mthi while busy must be ignored.
      applyStimulus(OP_MULT, 32'hFFFF_FFFD, 32'd5, 1'b1, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
      applyStimulus(OP_DIVU, 32'd99, 32'd3, 1'b1, 1'b1, 1'b0);
      waitDone(edges, busyCycles);
      checkOutput("ignore_timeout", 64'(edges < 999), 64'd1);
      checkOutput("ignore_hi", {32'd0, hi}, 64'h0000_0000_FFFF_FFFF);
      checkOutput("ignore_lo", {32'd0, lo}, 64'h0000_0000_FFFF_FFF1);

      // Back-to-back: new start in the done cycle.
      applyStimulus(OP_DIVU, 32'd100, 32'd7, 1'b1, 1'b0, 1'b0);
      waitDone(edges, busyCycles);
      checkOutput("b2b_latency", 64'(edges), 64'd34);
      checkOutput("b2b_hilo", {hi, lo}, 64'h0000_0002_0000_000E);

      // Reset during iteration 15 aborts the operation.
      @(negedge clk);
      applyStimulus(OP_MULTU, 32'd123456, 32'd789, 1'b1, 1'b0, 1'b0);
      repeat (17) @(negedge clk);
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(negedge clk);
      checkOutput("midreset_busy", {63'd0, busy}, 64'd0);
      checkOutput("midreset_done", {63'd0, done}, 64'd0);
      checkOutput("midreset_hilo", {hi, lo}, 64'd0);
      doneSeen = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (done) doneSeen++;
      end
      checkOutput("midreset_no_done", 64'(doneSeen), 64'd0);

      // mtlo in IDLE.
      applyStimulus(OP_MULT, 32'h0000_1234, 32'd0, 1'b0, 1'b0, 1'b1);
      @(negedge clk);
      checkOutput("mtlo_lo", {32'd0, lo}, 64'h0000_0000_0000_1234);
      checkOutput("mtlo_hi", {32'd0, hi}, 64'd0);
      checkOutput("mtlo_busy", {63'd0, busy}, 64'd0);

      // Randomized operations against the reference model.
      for (int i = 0; i < 12; i++) begin
         rop = 2'($urandom_range(0, 3));
         ra  = $urandom;
         rb  = $urandom;
         if (i % 4 == 2) rb = 32'($urandom_range(1, 20));
         if (i % 4 == 3) rb = 32'd0;
         doOp(rop, ra, rb, refModel(rop, ra, rb), $sformatf("rand%0d_op%0d", i, rop));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
